// File: rtl/repack_stream.sv
// Multi-lane LSB-first bit repacker: IN_W-bit lane words in, OUT_W-bit lane words out,
// with ready/valid on both sides, a flush that emits a zero-padded partial word, and a bit count per word.
//
// state    | meaning
// ST_ACC   | accepting input/flush, accumulating bits
// ST_PEND  | a flush arrived with a word-completing input; remainder waits for the output register
module repack_stream #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 21,
    parameter int N_CH  = 28,
    parameter int CW    = $clog2(OUT_W + 1)
) (
    input  logic                  clk,
    input  logic                  rstb,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N_CH*IN_W-1:0]  data_in,
    input  logic                  flush,
    output logic                  flush_ready,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [N_CH*OUT_W-1:0] data_out,
    output logic [CW-1:0]         out_nbits,
    output logic                  out_last,
    output logic [CW-1:0]         fill
);

    localparam int WW = IN_W + OUT_W;
    localparam int SW = $clog2(WW + 1);

    localparam logic [0:0] ST_ACC  = 1'b0;
    localparam logic [0:0] ST_PEND = 1'b1;

    localparam logic [1:0] OP_KEEP = 2'd0;
    localparam logic [1:0] OP_WIDE = 2'd1;
    localparam logic [1:0] OP_REM  = 2'd2;
    localparam logic [1:0] OP_CLR  = 2'd3;

    if (IN_W < 1 || IN_W > OUT_W || OUT_W > 64) begin : g_param_err
        $error("repack_stream: need 1 <= IN_W <= OUT_W <= 64");
    end

    logic [0:0]    state, state_n;
    logic          free, acc_in, full, load, sel_acc, last_n;
    logic [SW-1:0] sum;
    logic [CW-1:0] fill_n, nbits_n;
    logic [1:0]    acc_op;

    assign free        = !out_valid || out_ready;
    assign in_ready    = (state == ST_ACC) && free;
    assign flush_ready = in_ready;
    assign acc_in      = in_valid && in_ready;
    assign sum         = SW'(fill) + SW'(IN_W);
    assign full        = sum >= SW'(OUT_W);

    always_comb begin
        load    = 1'b0;
        sel_acc = 1'b0;
        nbits_n = '0;
        last_n  = 1'b0;
        acc_op  = OP_KEEP;
        fill_n  = fill;
        state_n = state;
        if (free) begin
            if (state == ST_PEND) begin
                load    = 1'b1;
                sel_acc = 1'b1;
                nbits_n = fill;
                last_n  = 1'b1;
                acc_op  = OP_CLR;
                fill_n  = '0;
                state_n = ST_ACC;
            end else if (acc_in) begin
                if (full) begin
                    load    = 1'b1;
                    nbits_n = CW'(OUT_W);
                    acc_op  = OP_REM;
                    fill_n  = CW'(sum - SW'(OUT_W));
                    // an exactly-aligned flush leaves nothing to emit afterwards
                    if (flush && sum != SW'(OUT_W))
                        state_n = ST_PEND;
                end else if (flush) begin
                    load    = 1'b1;
                    nbits_n = CW'(sum);
                    last_n  = 1'b1;
                    acc_op  = OP_CLR;
                    fill_n  = '0;
                end else begin
                    acc_op  = OP_WIDE;
                    fill_n  = CW'(sum);
                end
            end else if (flush && fill != '0) begin
                load    = 1'b1;
                sel_acc = 1'b1;
                nbits_n = fill;
                last_n  = 1'b1;
                acc_op  = OP_CLR;
                fill_n  = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state     <= ST_ACC;
            fill      <= '0;
            out_valid <= 1'b0;
            out_nbits <= '0;
            out_last  <= 1'b0;
        end else begin
            state <= state_n;
            fill  <= fill_n;
            if (load) begin
                out_valid <= 1'b1;
                out_nbits <= nbits_n;
                out_last  <= last_n;
            end else if (free) begin
                out_valid <= 1'b0;
            end
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_lane
        logic [OUT_W-1:0] acc, dreg;
        logic [WW-1:0]    wide, rem;

        // bits of acc at and above fill are zero, so OR-ing in the shifted word is exact
        assign wide = (WW'(data_in[i*IN_W +: IN_W]) << fill) | WW'(acc);
        assign rem  = wide >> OUT_W;
        assign data_out[i*OUT_W +: OUT_W] = dreg;

        always_ff @(posedge clk or negedge rstb) begin
            if (!rstb) begin
                acc  <= '0;
                dreg <= '0;
            end else begin
                case (acc_op)
                    OP_WIDE: acc <= wide[OUT_W-1:0];
                    OP_REM:  acc <= rem[OUT_W-1:0];
                    OP_CLR:  acc <= '0;
                    default: acc <= acc;
                endcase
                if (load)
                    dreg <= sel_acc ? acc : wide[OUT_W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_repack_stream.sv
// Bench for repack_stream: directed scenarios plus random traffic, checked against a
// per-lane bit-queue model of the packed stream.
module tb_repack_stream;
    localparam int IN_W  = 16;
    localparam int OUT_W = 21;
    localparam int N_CH  = 28;
    localparam int CW    = $clog2(OUT_W + 1);

    logic                  clk = 1'b0;
    logic                  rstb = 1'b1;
    logic                  in_valid = 1'b0;
    logic                  in_ready;
    logic [N_CH*IN_W-1:0]  data_in = '0;
    logic                  flush = 1'b0;
    logic                  flush_ready;
    logic                  out_valid;
    logic                  out_ready = 1'b1;
    logic [N_CH*OUT_W-1:0] data_out;
    logic [CW-1:0]         out_nbits;
    logic                  out_last;
    logic [CW-1:0]         fill;

    repack_stream #(.IN_W(IN_W), .OUT_W(OUT_W), .N_CH(N_CH)) dut (
        .clk(clk), .rstb(rstb), .in_valid(in_valid), .in_ready(in_ready),
        .data_in(data_in), .flush(flush), .flush_ready(flush_ready),
        .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out),
        .out_nbits(out_nbits), .out_last(out_last), .fill(fill)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N_CH*OUT_W-1:0] data;
        int                    nbits;
        bit                    last;
    } exp_t;

    exp_t         expq[$];
    logic [127:0] mbits[N_CH];
    int           mfill;
    int           checks = 0;
    int           failures = 0;
    int           pops = 0;
    int           accepts = 0;
    logic [N_CH*OUT_W-1:0] hold;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [N_CH*IN_W-1:0] rand_word();
        logic [N_CH*IN_W-1:0] w;
        for (int l = 0; l < N_CH; l++) w[l*IN_W +: IN_W] = IN_W'($urandom);
        return w;
    endfunction

    task automatic model_reset();
        expq.delete();
        mfill = 0;
        for (int l = 0; l < N_CH; l++) mbits[l] = '0;
    endtask

    task automatic emit(input int nb, input bit last);
        exp_t e;
        for (int l = 0; l < N_CH; l++) e.data[l*OUT_W +: OUT_W] = mbits[l][OUT_W-1:0];
        e.nbits = nb;
        e.last  = last;
        expq.push_back(e);
    endtask

    task automatic model_push(input logic [N_CH*IN_W-1:0] d);
        for (int l = 0; l < N_CH; l++)
            mbits[l] = mbits[l] | (128'(d[l*IN_W +: IN_W]) << mfill);
        mfill += IN_W;
        while (mfill >= OUT_W) begin
            emit(OUT_W, 1'b0);
            for (int l = 0; l < N_CH; l++) mbits[l] = mbits[l] >> OUT_W;
            mfill -= OUT_W;
        end
    endtask

    task automatic model_flush();
        if (mfill > 0) begin
            emit(mfill, 1'b1);
            for (int l = 0; l < N_CH; l++) mbits[l] = '0;
            mfill = 0;
        end
    endtask

    task automatic check_pop();
        exp_t e;
        checks++;
        assert (expq.size() != 0) else begin
            failures++;
            $error("FAIL out_unexpected observed=extra_word expected=no_word");
        end
        if (expq.size() != 0) begin
            e = expq.pop_front();
            checks++;
            assert (data_out === e.data && out_nbits === CW'(e.nbits) && out_last === e.last) else begin
                failures++;
                $error("FAIL out_word observed=%0h/%0d/%0b expected=%0h/%0d/%0b",
                       data_out, out_nbits, out_last, e.data, e.nbits, e.last);
            end
        end
        pops++;
    endtask

    // handshakes are decided mid-cycle; inputs change 1ns after the rising edge
    task automatic tick();
        bit ai, af, po;
        @(negedge clk);
        ai = in_valid && in_ready;
        af = flush && flush_ready;
        po = out_valid && out_ready;
        if (po) check_pop();
        if (ai) begin
            model_push(data_in);
            accepts++;
        end
        if (af) model_flush();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [IN_W-1:0] lane0);
        data_in = rand_word();
        data_in[IN_W-1:0] = lane0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        model_reset();
        #2 rstb = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_fill", 64'(fill), 64'd0);
        chk("rst_nbits", 64'(out_nbits), 64'd0);
        chk("rst_last", 64'(out_last), 64'd0);
        checks++;
        assert (data_out === '0) else begin
            failures++;
            $error("FAIL rst_data observed=%0h expected=0", data_out);
        end
        @(negedge clk) rstb = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_flush_ready", 64'(flush_ready), 64'd1);

        // basic carry-over then flush alone
        send(16'hAAAA);
        send(16'h5555);
        chk("basic_valid", 64'(out_valid), 64'd1);
        chk("basic_lane0", 64'(data_out[OUT_W-1:0]), 64'h15AAAA);
        chk("basic_nbits", 64'(out_nbits), 64'd21);
        chk("basic_fill", 64'(fill), 64'd11);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_valid", 64'(out_valid), 64'd1);
        chk("flush_lane0", 64'(data_out[OUT_W-1:0]), 64'h0002AA);
        chk("flush_nbits", 64'(out_nbits), 64'd11);
        chk("flush_last", 64'(out_last), 64'd1);
        chk("flush_fill", 64'(fill), 64'd0);
        tick();

        // long back-to-back stream
        pops = 0;
        accepts = 0;
        in_valid = 1'b1;
        for (int k = 0; k < 21; k++) begin
            data_in = rand_word();
            tick();
        end
        in_valid = 1'b0;
        tick();
        tick();
        chk("long_accepts", 64'(accepts), 64'd21);
        chk("long_outputs", 64'(pops), 64'd16);
        chk("long_fill", 64'(fill), 64'd0);

        // flush together with a word-completing input
        send(16'hAAAA);
        send(16'h5555);
        data_in = rand_word();
        data_in[IN_W-1:0] = 16'hFFFF;
        in_valid = 1'b1;
        flush = 1'b1;
        tick();
        in_valid = 1'b0;
        flush = 1'b0;
        chk("fwi_in_ready_low", 64'(in_ready), 64'd0);
        chk("fwi_full_lane0", 64'(data_out[OUT_W-1:0]), 64'h1FFAAA);
        chk("fwi_full_nbits", 64'(out_nbits), 64'd21);
        chk("fwi_full_last", 64'(out_last), 64'd0);
        tick();
        chk("fwi_in_ready_back", 64'(in_ready), 64'd1);
        chk("fwi_part_lane0", 64'(data_out[OUT_W-1:0]), 64'h00003F);
        chk("fwi_part_nbits", 64'(out_nbits), 64'd6);
        chk("fwi_part_last", 64'(out_last), 64'd1);
        chk("fwi_fill", 64'(fill), 64'd0);
        tick();

        // backpressure with an output pending
        send(16'hAAAA);
        send(16'h5555);
        out_ready = 1'b0;
        hold = data_out;
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            data_in = rand_word();
            tick();
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            chk("bp_out_valid", 64'(out_valid), 64'd1);
            checks++;
            assert (data_out === hold) else begin
                failures++;
                $error("FAIL bp_stable observed=%0h expected=%0h", data_out, hold);
            end
        end
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            data_in = rand_word();
            tick();
        end
        in_valid = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        repeat (3) tick();
        chk("bp_drained", 64'(expq.size()), 64'd0);

        // random traffic with random backpressure and flushes
        for (int k = 0; k < 400; k++) begin
            in_valid  = ($urandom % 4) != 0;
            flush     = ($urandom % 8) == 0;
            out_ready = ($urandom % 3) != 0;
            data_in   = rand_word();
            tick();
        end
        in_valid = 1'b0;
        flush = 1'b0;
        out_ready = 1'b1;
        repeat (3) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        repeat (3) tick();
        chk("rand_drained", 64'(expq.size()), 64'd0);
        chk("rand_fill", 64'(fill), 64'd0);

        // reset mid-stream with a word pending
        send(16'hAAAA);
        send(16'h5555);
        rstb = 1'b0;
        #1;
        chk("mrst_out_valid", 64'(out_valid), 64'd0);
        chk("mrst_fill", 64'(fill), 64'd0);
        model_reset();
        @(negedge clk) rstb = 1'b1;
        @(posedge clk);
        #1;
        send(16'hAAAA);
        chk("mrst_fill16", 64'(fill), 64'd16);
        chk("mrst_no_out", 64'(out_valid), 64'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("mrst_lane0", 64'(data_out[OUT_W-1:0]), 64'h00AAAA);
        chk("mrst_nbits", 64'(out_nbits), 64'd16);
        chk("mrst_last", 64'(out_last), 64'd1);
        tick();
        tick();
        chk("final_drained", 64'(expq.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
